// File: rtl/datamem_responder.sv
// datamem_responder
//   Word-addressed data memory on the CPU data port. Services single-cycle
//   writes and registered reads, raises a sticky stop on the end-of-program
//   store sentinel, and streams the full memory image out over a
//   valid/ready dump port when show rises.
//
// Ports
//   clk, rst                : clock, asynchronous active-high reset
//   mem_datamem_ce          : request valid
//   mem_datamem_wrn         : 1 = write, 0 = read
//   mem_datamem_addr        : byte address (bits [1:0] ignored)
//   mem_datamem_wrdata      : write data
//   datamem_mem_redata      : registered read data (0 for out-of-range)
//   show                    : dump request, rising-edge sensitive
//   dump_valid/dump_ready   : dump handshake
//   dump_addr, dump_data    : byte address and contents of the dump word
//   dump_done               : one-cycle pulse after the last word is taken
//   stop                    : sticky halt flag
module datamem_responder #(
  parameter int unsigned DEPTH = 512,
  parameter int unsigned AW    = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_datamem_ce,
  input  logic        mem_datamem_wrn,
  input  logic [31:0] mem_datamem_addr,
  input  logic [31:0] mem_datamem_wrdata,
  output logic [31:0] datamem_mem_redata,
  input  logic        show,
  output logic        dump_valid,
  input  logic        dump_ready,
  output logic [31:0] dump_addr,
  output logic [31:0] dump_data,
  output logic        dump_done,
  output logic        stop
);

  typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_t;

  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] idx;
  logic          in_range;
  logic          rd_req;
  logic          wr_req;
  logic          sentinel;
  logic          show_q;

  state_t        state, state_next;
  logic [AW-1:0] ptr, ptr_next;
  logic          load_dump;

  assign idx      = mem_datamem_addr[AW+1:2];
  assign in_range = (mem_datamem_addr[31:AW+2] == '0);
  assign rd_req   = mem_datamem_ce & ~mem_datamem_wrn;
  assign wr_req   = mem_datamem_ce &  mem_datamem_wrn;
  assign sentinel = wr_req & (mem_datamem_addr == '1) & (mem_datamem_wrdata == '1);

  // Memory array carries no reset: contents survive rst.
  always_ff @(posedge clk) begin
    if (wr_req && in_range && !sentinel)
      mem[idx] <= mem_datamem_wrdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      datamem_mem_redata <= '0;
      stop               <= 1'b0;
      show_q             <= 1'b0;
    end else begin
      show_q <= show;
      if (sentinel)
        stop <= 1'b1;
      if (rd_req)
        datamem_mem_redata <= in_range ? mem[idx] : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      dump_data <= '0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
      // Non-blocking read of mem: a CPU write to mem[ptr] on this same edge
      // is not seen, giving read-before-write.
      if (load_dump)
        dump_data <= mem[ptr];
    end
  end

  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    load_dump  = 1'b0;
    dump_valid = 1'b0;
    dump_done  = 1'b0;
    case (state)
      IDLE: begin
        if (show && !show_q) begin
          ptr_next   = '0;
          state_next = FETCH;
        end
      end
      FETCH: begin
        // A CPU read owns the read port; retry the fetch next cycle.
        if (!rd_req) begin
          load_dump  = 1'b1;
          state_next = SEND;
        end
      end
      SEND: begin
        dump_valid = 1'b1;
        if (dump_ready) begin
          if (ptr == LAST_PTR) begin
            state_next = DONE;
          end else begin
            ptr_next   = ptr + 1'b1;
            state_next = FETCH;
          end
        end
      end
      DONE: begin
        dump_done  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign dump_addr = {{(32 - AW - 2){1'b0}}, ptr, 2'b00};

endmodule

// File: tb/tb_datamem_responder.sv
// tb_datamem_responder
//   Directed bench for datamem_responder: reset values, read/write,
//   out-of-range handling, halt sentinel, dump with random backpressure,
//   CPU/dump read-port collision, reset mid-dump and dump restart timing.
module tb_datamem_responder;

  localparam int unsigned DEPTH = 512;
  localparam int unsigned AW    = 9;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce = 1'b0;
  logic        wrn = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wrdata = '0;
  logic [31:0] redata;
  logic        show = 1'b0;
  logic        dump_valid;
  logic        dump_ready = 1'b0;
  logic [31:0] dump_addr;
  logic [31:0] dump_data;
  logic        dump_done;
  logic        stop;

  int total = 0;
  int bad   = 0;

  datamem_responder #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk                (clk),
    .rst                (rst),
    .mem_datamem_ce     (ce),
    .mem_datamem_wrn    (wrn),
    .mem_datamem_addr   (addr),
    .mem_datamem_wrdata (wrdata),
    .datamem_mem_redata (redata),
    .show               (show),
    .dump_valid         (dump_valid),
    .dump_ready         (dump_ready),
    .dump_addr          (dump_addr),
    .dump_data          (dump_data),
    .dump_done          (dump_done),
    .stop               (stop)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    ce = 1'b1; wrn = 1'b1; addr = a; wrdata = d;
    step();
    ce = 1'b0; wrn = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a);
    ce = 1'b1; wrn = 1'b0; addr = a;
    step();
    ce = 1'b0;
  endtask

  initial begin
    int hs_cnt;
    int done_cnt;
    int cyc;
    int last_hs;
    int n;
    logic stalled;
    logic [31:0] prev_addr;
    logic [31:0] prev_data;
    logic found;

    // Reset values
    step(); step();
    check("rst_redata", redata, 32'h0);
    check("rst_stop", {31'b0, stop}, 32'h0);
    check("rst_valid", {31'b0, dump_valid}, 32'h0);
    check("rst_done", {31'b0, dump_done}, 32'h0);
    check("rst_daddr", dump_addr, 32'h0);
    check("rst_ddata", dump_data, 32'h0);
    rst = 1'b0;
    step();

    // Fill mem[i] = 3*i
    for (int i = 0; i < DEPTH; i++) wr(32'(4 * i), 32'(3 * i));

    // Basic read/write
    wr(32'h10, 32'hDEADBEEF);
    rd(32'h10);
    check("rw_10", redata, 32'hDEADBEEF);
    rd(32'h14);
    check("rw_14", redata, 32'd15);
    wr(32'h10, 32'd12);
    rd(32'h10);
    check("rw_10_restore", redata, 32'd12);

    // Out of range (idx 512 does not exist)
    wr(32'h800, 32'h1234);
    rd(32'h800);
    check("oor_800", redata, 32'h0);
    rd(32'h0);
    check("oor_mem0", redata, 32'h0);
    rd(32'h4);
    check("oor_mem1", redata, 32'd3);

    // Halt sentinel
    check("stop_before", {31'b0, stop}, 32'h0);
    wr(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("stop_set", {31'b0, stop}, 32'h1);
    rd(32'h7FC);
    check("sent_7fc", redata, 32'd1533);
    step(); step();
    check("stop_sticky", {31'b0, stop}, 32'h1);

    // Dump with random backpressure
    dump_ready = 1'b0;
    show = 1'b1;
    step();
    check("dump_fetch_novalid", {31'b0, dump_valid}, 32'h0);
    show = 1'b0;
    step();
    check("dump_first_valid", {31'b0, dump_valid}, 32'h1);
    check("dump_first_addr", dump_addr, 32'h0);
    check("dump_first_data", dump_data, 32'h0);
    hs_cnt = 0; done_cnt = 0; cyc = 0; last_hs = -10;
    stalled = 1'b0; prev_addr = '0; prev_data = '0;
    while (cyc < 20000 && !(done_cnt > 0 && cyc > last_hs + 8)) begin
      if (stalled) begin
        check("stall_valid", {31'b0, dump_valid}, 32'h1);
        check("stall_addr", dump_addr, prev_addr);
        check("stall_data", dump_data, prev_data);
      end
      if (dump_done) begin
        done_cnt++;
        check("done_after_last_hs", 32'(cyc - last_hs), 32'd1);
      end
      dump_ready = 1'($urandom_range(0, 1));
      stalled = dump_valid & ~dump_ready;
      prev_addr = dump_addr;
      prev_data = dump_data;
      if (dump_valid && dump_ready) begin
        check("hs_addr", dump_addr, 32'(4 * hs_cnt));
        check("hs_data", dump_data, 32'(3 * hs_cnt));
        hs_cnt++;
        last_hs = cyc;
      end
      step();
      cyc++;
    end
    check("dump_no_timeout", {31'b0, (cyc < 20000)}, 32'h1);
    check("dump_hs_count", 32'(hs_cnt), 32'd512);
    check("dump_done_count", 32'(done_cnt), 32'd1);

    // Port collision: CPU reads hold the FSM in FETCH
    dump_ready = 1'b1;
    show = 1'b1;
    step();
    show = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      step();
      if (dump_valid && dump_addr == 32'd12) found = 1'b1;
    end
    check("coll_reach_word3", {31'b0, found}, 32'h1);
    step();
    check("coll_fetch_novalid", {31'b0, dump_valid}, 32'h0);
    for (int j = 0; j < 5; j++) begin
      ce = 1'b1; wrn = 1'b0; addr = 32'(4 * (20 + j));
      step();
      check("coll_valid_low", {31'b0, dump_valid}, 32'h0);
      check("coll_cpu_read", redata, 32'(3 * (20 + j)));
    end
    ce = 1'b0;
    step();
    check("coll_resume_valid", {31'b0, dump_valid}, 32'h1);
    check("coll_resume_addr", dump_addr, 32'd16);
    check("coll_resume_data", dump_data, 32'd12);

    // Reset mid-dump at ptr 100
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      step();
      if (dump_valid && dump_addr == 32'd400) found = 1'b1;
    end
    check("rmd_reach_ptr100", {31'b0, found}, 32'h1);
    check("rmd_stop_before_rst", {31'b0, stop}, 32'h1);
    rst = 1'b1;
    #1;
    check("rmd_valid_async", {31'b0, dump_valid}, 32'h0);
    step();
    rst = 1'b0;
    check("rmd_stop_cleared", {31'b0, stop}, 32'h0);
    check("rmd_daddr", dump_addr, 32'h0);
    check("rmd_ddata", dump_data, 32'h0);
    check("rmd_redata", redata, 32'h0);
    for (int i = 0; i < 6; i++) begin
      step();
      check("rmd_no_resume", {31'b0, dump_valid}, 32'h0);
    end
    rd(32'd400);
    check("rmd_mem100", redata, 32'd300);
    rd(32'h0);
    check("rmd_mem0", redata, 32'h0);

    // Restart dump, ready held high: timing and first word
    dump_ready = 1'b1;
    show = 1'b1;
    n = 0;
    found = 1'b0;
    // Show edge is sampled at edge n=1; last handshake at n=2*DEPTH, done
    // visible after edge n=2*DEPTH+1.
    while (n < 3000 && !found) begin
      step();
      n++;
      if (n == 1) show = 1'b0;
      if (n == 2) begin
        check("rs_first_valid", {31'b0, dump_valid}, 32'h1);
        check("rs_first_addr", dump_addr, 32'h0);
        check("rs_first_data", dump_data, 32'h0);
      end
      if (dump_done) found = 1'b1;
    end
    check("rs_done_seen", {31'b0, found}, 32'h1);
    check("rs_done_cycle", 32'(n), 32'(2 * DEPTH + 1));
    step();
    check("rs_done_one_cycle", {31'b0, dump_done}, 32'h0);
    check("rs_idle_novalid", {31'b0, dump_valid}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
